// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade driver.
// LEVEL_MAX is the full-brightness code.
package led_pkg;

    localparam int N_LEDS   = 8;
    localparam int PWM_BITS = 8;

    typedef logic [PWM_BITS-1:0] level_t;

    localparam level_t LEVEL_MAX = level_t'((2 ** PWM_BITS) - 1);

    typedef enum logic [1:0] {
        CH_OFF,
        CH_ON,
        CH_FADE
    } ch_state_t;

    // Saturating subtract: the result never wraps below zero.
    function automatic level_t sat_sub(input level_t a, input level_t b);
        return (a > b) ? level_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / PWM-out bundle between the chaser and the LED pins.
interface led_fade_driver_if;
    import led_pkg::*;

    logic [N_LEDS-1:0] led_in;
    logic [N_LEDS-1:0] led_out;
    logic              decay_tick;

    modport master (output led_in, input led_out, input decay_tick);
    modport slave  (input led_in, output led_out, output decay_tick);

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with saturating decay and the PWM compare flop.
//   state   | meaning
//   CH_OFF  | level is 0, LED dark
//   CH_ON   | input lit, level held at LEVEL_MAX
//   CH_FADE | input dark, level > 0 and decaying on each tick
module led_fade_channel
    import led_pkg::*;
#(
    parameter int DECAY_STEP = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   led_q,
    input  logic   decay_tick,
    input  level_t pwm_cnt,
    output logic   led_out
);

    localparam level_t STEP = level_t'(DECAY_STEP);

    level_t    level;
    level_t    level_nxt;
    ch_state_t state;

    // A lit input beats a coincident decay tick.
    always_comb begin
        level_nxt = level;
        if (led_q) begin
            level_nxt = LEVEL_MAX;
        end else if (decay_tick) begin
            level_nxt = sat_sub(level, STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level   <= '0;
            led_out <= 1'b0;
            state   <= CH_OFF;
        end else begin
            level   <= level_nxt;
            led_out <= (level == LEVEL_MAX) || (level > pwm_cnt);
            case (state)
                CH_OFF: begin
                    if (led_q) state <= CH_ON;
                end
                CH_ON: begin
                    if (!led_q) state <= (level_nxt == '0) ? CH_OFF : CH_FADE;
                end
                CH_FADE: begin
                    if (led_q) begin
                        state <= CH_ON;
                    end else if (level_nxt == '0) begin
                        state <= CH_OFF;
                    end
                end
                default: state <= CH_OFF;
            endcase
        end
    end

    a_off_dark : assert property (@(posedge clk) disable iff (!reset)
        (state == CH_OFF) |-> (level == '0));
    a_on_full  : assert property (@(posedge clk) disable iff (!reset)
        (state == CH_ON) |-> (level == LEVEL_MAX));
    a_fade_lit : assert property (@(posedge clk) disable iff (!reset)
        (state == CH_FADE) |-> (level != '0));

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade stage behind the LED chaser: lit LEDs run at full duty,
// released LEDs fade out linearly to give the chase a trailing tail.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int DECAY_DIV  = 195312,
    parameter int DECAY_STEP = 4
) (
    input  logic clk,
    input  logic reset,
    led_fade_driver_if.slave bus
);

    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [N_LEDS-1:0] led_q;
    logic [N_LEDS-1:0] led_out_w;
    level_t            pwm_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              decay_tick;

    assign decay_tick = (div_cnt == DIV_LAST);

    // Chaser shares this clock, so one register stage is enough.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q   <= '0;
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            led_q   <= bus.led_in;
            pwm_cnt <= pwm_cnt + 1'b1;
            div_cnt <= decay_tick ? '0 : div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .led_q      (led_q[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .led_out    (led_out_w[i])
        );
    end

    assign bus.led_out    = led_out_w;
    assign bus.decay_tick = decay_tick;

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream PWM stage for the LED chaser. It consumes the chaser's 8-bit on/off pattern and drives the board LEDs. A lit input LED is driven at full brightness, and an LED that switches off fades out linearly instead of cutting off, which gives the chase a trailing comet effect. The block sits between the chaser's `LEDS` output and the `LEDR` pins, on the same `clk` (CLOCK_50) and the same reset (SW0).

## Interface
- `N_LEDS`, 8: number of channels.
- `PWM_BITS`, 8: brightness/PWM resolution. `LEVEL_MAX = 2**PWM_BITS-1`.
- `DECAY_DIV`, 195312: clk cycles per decay tick (≈256 Hz at 50 MHz).
- `DECAY_STEP`, 4: level decrement per decay tick.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  reset, synchronous, active-low.
- `led_in`  in  N_LEDS  on/off pattern from the chaser; may be asynchronous to any PWM phase.
- `led_out`  out  N_LEDS  registered PWM drive to the LED pins.
- `decay_tick`  out  1  one-cycle strobe marking each decay step; debug/verification only.

## Operation
- `pwm_cnt` (PWM_BITS) is free-running: +1 every cycle, wraps `LEVEL_MAX`→0.
- `div_cnt` counts 0..DECAY_DIV-1.
  - `decay_tick`=1 in the cycle where `div_cnt==DECAY_DIV-1`.
  - `div_cnt` then wraps to 0.
- `led_in` is registered once into `led_q`. There is no further synchronisation; the chaser is on the same clock.
- Per-channel `level[i]` (PWM_BITS). Priority order each cycle:
  1. `led_q[i]==1` → `level[i] <= LEVEL_MAX`. This wins over a coincident `decay_tick`.
  2. Else if `decay_tick` → `level[i] <= (level[i] > DECAY_STEP) ? level[i]-DECAY_STEP : 0`. The subtraction saturates and never wraps below 0.
  3. Else hold.
- Per-channel state, derived from `level` and `led_q`:
  - OFF (`level`=0): → ON when `led_q`=1.
  - ON (`led_q`=1): → FADE when `led_q`=0.
  - FADE (`level`>0, `led_q`=0): → ON when `led_q`=1; → OFF when `level` reaches 0.
- Output, registered: `led_out[i] <= (level[i]==LEVEL_MAX) || (level[i] > pwm_cnt)`.
  - `level`=MAX: 100% duty.
  - `level`=0: 0% duty.
  - Otherwise: `level`/256 duty per PWM period.
- Fade length from full: `ceil(LEVEL_MAX/DECAY_STEP)` ticks. With defaults, 64 ticks ≈ 250 ms.

## Timing
- Reset, when `reset`=0 at a clk edge: `led_q`, all `level`, `pwm_cnt`, `div_cnt`, `led_out`=0 and `decay_tick`=0 after that edge.
  - Reset applies mid-fade as well; there is no residual brightness.
  - First tick occurs DECAY_DIV cycles after reset release.
- Latency, `led_in` → `led_out`: 2 edges.
  - `led_in` sampled at edge E.
  - `level` updated at E+1.
  - `led_out` valid after E+2.
- `level` decrements exactly on the edge following the `decay_tick`-high cycle. There is at most one decrement per tick.
- Pattern changes are accepted every cycle; no handshake is involved.

## Structure
- Package `led_pkg` holds:
  - `N_LEDS`, `PWM_BITS` and `LEVEL_MAX` constants.
  - The channel state enum `{CH_OFF, CH_ON, CH_FADE}`, used for assertions and debug.
- Sub-module `led_fade_channel` implements one channel: the `level` register, its saturating decrement and the compare/output flop.
  - The top instantiates `N_LEDS` copies in a generate loop.
  - The top owns the shared `pwm_cnt`, `div_cnt`/`decay_tick` and `led_q`.

## Test plan
Bench overrides: `DECAY_DIV`=4, `DECAY_STEP`=64.
- **Reset:** `reset`=0 for 3 cycles with `led_in`=8'hFF → `led_out`=8'h00, `decay_tick`=0, `pwm_cnt`=0 throughout. Release reset → first `decay_tick` 4 cycles later.
- **Steady on:** `led_in`=8'h01 held → `led_out`=8'h01 every cycle from E+2 on, for more than 512 cycles with no gaps.
- **Linear fade:** `led_in` 8'h01→8'h00 → `level[0]` steps 255→191→127→63→0 on consecutive ticks. Over a 256-cycle PWM window at level 191, `led_out[0]` is high for exactly 191 cycles. After the 4th tick, `led_out[0]` is 0 permanently.
- **Re-arm during fade:** reassert `led_in[0]` in the same cycle as `decay_tick`, at `level`=127 → `level`=255 next edge with no decrement; `led_out[0]` is solid again after E+2.
- **Chase trail:** `led_in` walks 8'h01,8'h02,8'h04 with a 4-cycle step → the active channel is at level 255 and the previous channels are at strictly lower, non-increasing levels. No level underflows past 0.
- **Reset mid-fade:** assert `reset` while channels 0–2 are in FADE → all levels and `led_out` are 0 after one edge, and no channel resumes its fade after release.
